bsg_config_rom_slave: RTL and testbench

Read-only configuration ROM slave that answers word reads from a manycore-style request port with constant, parameter-defined configuration words. It sits behind the network endpoint of the host-visible configuration tile. Reads return masked ROM data one cycle after acceptance. Writes are illegal; they are consumed, produce no response, and raise an error pulse.

---
 rtl/bsg_config_rom_slave.sv | 103 ++++++++++
 tb/tb_bsg_config_rom_slave.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_config_rom_slave.sv
// rtl/bsg_config_rom_slave.sv - read-only configuration ROM slave on a manycore-style request port
// Reads return masked ROM words one cycle after acceptance; writes are consumed and flagged.
module bsg_config_rom_slave #(
  parameter int rom_width_p  = 32,
  parameter int rom_els_p    = 1,
  parameter logic [rom_width_p*rom_els_p-1:0] rom_init_p = '0,
  parameter int data_width_p = 32,
  parameter int addr_width_p = 28,
  localparam int data_mask_width_lp = data_width_p / 8,
  localparam int lg_rom_els_lp      = (rom_els_p > 1) ? $clog2(rom_els_p) : 1
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          in_v_i,
  output logic                          in_yumi_o,
  input  logic                          in_we_i,
  input  logic [addr_width_p-1:0]       in_addr_i,
  input  logic [data_mask_width_lp-1:0] in_mask_i,
  input  logic [data_width_p-1:0]       in_data_i,
  output logic                          returning_v_o,
  output logic [data_width_p-1:0]       returning_data_o,
  input  logic                          returning_ready_i,
  output logic                          write_err_o
);

  if (rom_width_p > data_width_p) begin : g_bad_rom_width
    $error("bsg_config_rom_slave: rom_width_p (%0d) exceeds data_width_p (%0d)", rom_width_p, data_width_p);
  end
  if (lg_rom_els_lp > addr_width_p) begin : g_bad_addr_width
    $error("bsg_config_rom_slave: addr_width_p (%0d) narrower than ROM index (%0d)", addr_width_p, lg_rom_els_lp);
  end

  logic                          v_q, v_d;
  logic                          err_q, err_d;
  logic [data_width_p-1:0]       data_q, data_d;
  logic [data_mask_width_lp-1:0] mask_q, mask_d;

  logic [lg_rom_els_lp-1:0] rom_idx;
  logic [data_width_p-1:0]  rom_data;
  logic                     accept;
  logic                     unused_inputs;

  assign unused_inputs = ^{in_data_i, in_addr_i};
  assign rom_idx       = in_addr_i[lg_rom_els_lp-1:0];

  // Indices beyond rom_els_p never match and therefore read as zero.
  always_comb begin
    rom_data = '0;
    for (int i = 0; i < rom_els_p; i++) begin
      if (rom_idx == lg_rom_els_lp'(i)) begin
        rom_data[rom_width_p-1:0] = rom_init_p[i*rom_width_p +: rom_width_p];
      end
    end
  end

  assign accept    = in_v_i & (~v_q | returning_ready_i);
  assign in_yumi_o = accept;

  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    mask_d = mask_q;
    err_d  = accept & in_we_i;
    if (accept & ~in_we_i) begin
      v_d    = 1'b1;
      data_d = rom_data;
      mask_d = in_mask_i;
    end else if (v_q & returning_ready_i) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v_q    <= 1'b0;
      err_q  <= 1'b0;
      data_q <= '0;
      mask_q <= '0;
    end else begin
      v_q    <= v_d;
      err_q  <= err_d;
      data_q <= data_d;
      mask_q <= mask_d;
    end
  end

  always_comb begin
    returning_data_o = '0;
    for (int b = 0; b < data_mask_width_lp; b++) begin
      returning_data_o[b*8 +: 8] = mask_q[b] ? data_q[b*8 +: 8] : 8'h00;
    end
  end

  assign returning_v_o = v_q;
  assign write_err_o   = err_q;

  always @(posedge clk_i) begin
    if (!reset_i && accept && in_we_i) begin
      $warning("bsg_config_rom_slave: illegal write to read-only ROM at addr 0x%h", in_addr_i);
    end
  end

endmodule

// File: tb/tb_bsg_config_rom_slave.sv
// tb/tb_bsg_config_rom_slave.sv - self-checking bench for bsg_config_rom_slave
// Reference model tracks accept/response/error state from the block's rules; directed vectors add literal checks.
module tb_bsg_config_rom_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_v;
  logic        in_yumi;
  logic        in_we;
  logic [27:0] in_addr;
  logic [3:0]  in_mask;
  logic [31:0] in_data;
  logic        ret_v;
  logic [31:0] ret_data;
  logic        ret_ready;
  logic        werr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bsg_config_rom_slave #(
    .rom_width_p (32),
    .rom_els_p   (4),
    .rom_init_p  (128'h00000003_12345678_DEADBEEF_00000001),
    .data_width_p(32),
    .addr_width_p(28)
  ) dut (
    .clk_i            (clk),
    .reset_i          (rst),
    .in_v_i           (in_v),
    .in_yumi_o        (in_yumi),
    .in_we_i          (in_we),
    .in_addr_i        (in_addr),
    .in_mask_i        (in_mask),
    .in_data_i        (in_data),
    .returning_v_o    (ret_v),
    .returning_data_o (ret_data),
    .returning_ready_i(ret_ready),
    .write_err_o      (werr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference
  logic [31:0] rom_tbl [4];
  initial begin
    rom_tbl[0] = 32'h0000_0001;
    rom_tbl[1] = 32'hDEAD_BEEF;
    rom_tbl[2] = 32'h1234_5678;
    rom_tbl[3] = 32'h0000_0003;
  end

  function automatic logic [31:0] exp_word(input logic [27:0] addr, input logic [3:0] mask);
    logic [31:0] w;
    logic [31:0] r;
    w = rom_tbl[int'(addr % 28'd4)];
    r = 32'h0;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) r = r | (w & (32'hFF << (8 * b)));
    end
    return r;
  endfunction

  logic        m_v;
  logic [31:0] m_data;
  logic        m_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_v    <= 1'b0;
      m_data <= 32'h0;
      m_err  <= 1'b0;
    end else begin
      m_err <= in_v && (!m_v || ret_ready) && in_we;
      if (in_v && (!m_v || ret_ready) && !in_we) begin
        m_v    <= 1'b1;
        m_data <= exp_word(in_addr, in_mask);
      end else if (m_v && ret_ready) begin
        m_v <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_yumi", {31'h0, in_yumi}, {31'h0, in_v && (!m_v || ret_ready)});
    chk("cmp_ret_v", {31'h0, ret_v}, {31'h0, m_v});
    chk("cmp_werr", {31'h0, werr}, {31'h0, m_err});
    if (m_v || rst) chk("cmp_ret_data", ret_data, m_data);
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [27:0] a, input logic [3:0] m, input logic rdy);
    in_v      = v;
    in_we     = we;
    in_addr   = a;
    in_mask   = m;
    in_data   = 32'hA5A5_5A5A;
    ret_ready = rdy;
  endtask

  logic [31:0] b2b_exp [4];

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    b2b_exp[0] = 32'h0000_0001;
    b2b_exp[1] = 32'hDEAD_BEEF;
    b2b_exp[2] = 32'h1234_5678;
    b2b_exp[3] = 32'h0000_0003;

    rst = 1'b1;
    drive(0, 0, 28'h0, 4'h0, 1);
    cyc();
    cyc();
    chk("reset_ret_v", {31'h0, ret_v}, 32'h0);
    chk("reset_ret_data", ret_data, 32'h0);
    chk("reset_werr", {31'h0, werr}, 32'h0);
    rst = 1'b0;
    cyc();

    // 1: single read
    drive(1, 0, 28'd1, 4'hF, 1);
    #1 chk("t1_yumi", {31'h0, in_yumi}, 32'h1);
    cyc();
    drive(0, 0, 28'h0, 4'h0, 1);
    chk("t1_ret_v", {31'h0, ret_v}, 32'h1);
    chk("t1_data", ret_data, 32'hDEAD_BEEF);
    cyc();
    chk("t1_ret_v_drop", {31'h0, ret_v}, 32'h0);

    // 2: byte masking
    drive(1, 0, 28'd1, 4'b0101, 1);
    cyc();
    drive(1, 0, 28'd2, 4'b1000, 1);
    chk("t2_mask0101", ret_data, 32'h00AD_00EF);
    cyc();
    drive(0, 0, 28'h0, 4'h0, 1);
    chk("t2_mask1000", ret_data, 32'h1200_0000);
    cyc();

    // 3: address wrap
    drive(1, 0, 28'd5, 4'hF, 1);
    cyc();
    drive(1, 0, 28'h7FF_FFFC, 4'hF, 1);
    chk("t3_wrap5", ret_data, 32'hDEAD_BEEF);
    cyc();
    drive(0, 0, 28'h0, 4'h0, 1);
    chk("t3_wrap_hi", ret_data, 32'h0000_0001);
    cyc();

    // 4: back-to-back
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 28'(i), 4'hF, 1);
      cyc();
      chk("t4_b2b_v", {31'h0, ret_v}, 32'h1);
      chk("t4_b2b_data", ret_data, b2b_exp[i]);
    end
    drive(0, 0, 28'h0, 4'h0, 1);
    cyc();

    // 5: backpressure
    drive(1, 0, 28'd3, 4'hF, 1);
    cyc();
    drive(1, 0, 28'd0, 4'hF, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("t5_hold_yumi", {31'h0, in_yumi}, 32'h0);
      chk("t5_hold_data", ret_data, 32'h0000_0003);
      cyc();
    end
    ret_ready = 1'b1;
    #1 chk("t5_release_yumi", {31'h0, in_yumi}, 32'h1);
    cyc();
    drive(0, 0, 28'h0, 4'h0, 1);
    chk("t5_after_data", ret_data, 32'h0000_0001);
    cyc();

    // 6: illegal write, ROM unchanged, reset while pending
    drive(1, 1, 28'd2, 4'hF, 1);
    #1 chk("t6_write_yumi", {31'h0, in_yumi}, 32'h1);
    cyc();
    drive(0, 0, 28'h0, 4'h0, 1);
    chk("t6_werr", {31'h0, werr}, 32'h1);
    chk("t6_no_resp", {31'h0, ret_v}, 32'h0);
    cyc();
    chk("t6_werr_pulse", {31'h0, werr}, 32'h0);
    drive(1, 0, 28'd2, 4'hF, 1);
    cyc();
    drive(1, 0, 28'd1, 4'hF, 0);
    chk("t6_rom_intact", ret_data, 32'h1234_5678);
    cyc();
    drive(0, 0, 28'h0, 4'h0, 0);
    chk("t6_pending", {31'h0, ret_v}, 32'h1);
    rst = 1'b1;
    #1 chk("t6_reset_drop", {31'h0, ret_v}, 32'h0);
    chk("t6_reset_data", ret_data, 32'h0);
    cyc();
    rst = 1'b0;
    in_v = 1'b1;
    #1 chk("t6_yumi_after_reset", {31'h0, in_yumi}, 32'h1);
    in_v = 1'b0;
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
